// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate load/store cache
// sitting between the MEM stage and the SRAM controller (64-bit lines, 32-bit words).
module cache_controller #(
  parameter int SETS  = 64,
  parameter int TAG_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_r_en,
  output logic        sram_w_en,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);
  localparam int IDX_W = $clog2(SETS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    WRITE     = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [63:0]      data0_q [SETS];
  logic [63:0]      data1_q [SETS];
  logic [TAG_W-1:0] tag0_q  [SETS];
  logic [TAG_W-1:0] tag1_q  [SETS];
  logic             valid0_q [SETS];
  logic             valid1_q [SETS];
  logic             lru_q    [SETS];

  logic             word_sel;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit0, hit1, hit;
  logic             victim;
  logic [31:0]      hit_word;
  logic             fill_en, wr_hit_en, lru_we, lru_d;
  logic             unused_addr;

  assign word_sel     = address[2];
  assign idx          = address[3 +: IDX_W];
  assign tag          = address[3+IDX_W +: TAG_W];
  assign unused_addr  = ^{address[31:3+IDX_W+TAG_W], address[1:0]};
  assign sram_address = address;
  assign sram_wdata   = wdata;

  assign hit0   = valid0_q[idx] & (tag0_q[idx] == tag);
  assign hit1   = valid1_q[idx] & (tag1_q[idx] == tag);
  assign hit    = hit0 | hit1;
  assign victim = lru_q[idx];

  always_comb begin
    hit_word = '0;
    if (hit0)      hit_word = word_sel ? data0_q[idx][63:32] : data0_q[idx][31:0];
    else if (hit1) hit_word = word_sel ? data1_q[idx][63:32] : data1_q[idx][31:0];
  end

  // Next state, handshake outputs and the cache/LRU write strobes.
  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    rdata     = '0;
    sram_r_en = 1'b0;
    sram_w_en = 1'b0;
    fill_en   = 1'b0;
    wr_hit_en = 1'b0;
    lru_we    = 1'b0;
    lru_d     = 1'b0;
    case (state_q)
      IDLE: begin
        ready = (~MEM_R_EN & ~MEM_W_EN) | (MEM_R_EN & ~MEM_W_EN & hit);
        if (MEM_W_EN) begin
          state_d = WRITE;
        end else if (MEM_R_EN && !hit) begin
          state_d = READ_MISS;
        end else if (MEM_R_EN) begin
          rdata  = hit_word;
          lru_we = 1'b1;
          lru_d  = hit0;
        end
      end
      READ_MISS: begin
        sram_r_en = 1'b1;
        ready     = sram_ready;
        if (sram_ready) begin
          rdata   = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
          fill_en = 1'b1;
          lru_we  = 1'b1;
          lru_d   = ~victim;
          state_d = IDLE;
        end
      end
      WRITE: begin
        sram_w_en = 1'b1;
        ready     = sram_ready;
        if (sram_ready) begin
          state_d = IDLE;
          if (hit) begin
            wr_hit_en = 1'b1;
            lru_we    = 1'b1;
            lru_d     = hit0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) begin
        valid0_q[i] <= 1'b0;
        valid1_q[i] <= 1'b0;
        lru_q[i]    <= 1'b0;
      end
    end else begin
      if (fill_en) begin
        if (victim) valid1_q[idx] <= 1'b1;
        else        valid0_q[idx] <= 1'b1;
      end
      if (lru_we) lru_q[idx] <= lru_d;
    end
  end

  // Data and tags carry no reset: valid bits alone decide whether they mean anything.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      if (victim) begin
        data1_q[idx] <= sram_rdata;
        tag1_q[idx]  <= tag;
      end else begin
        data0_q[idx] <= sram_rdata;
        tag0_q[idx]  <= tag;
      end
    end
    if (wr_hit_en) begin
      if (hit0) begin
        if (word_sel) data0_q[idx][63:32] <= wdata;
        else          data0_q[idx][31:0]  <= wdata;
      end else begin
        if (word_sel) data1_q[idx][63:32] <= wdata;
        else          data1_q[idx][31:0]  <= wdata;
      end
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: behavioural SRAM controller, vector table
// of loads/stores with hand-computed results, and a reset-during-miss sequence.
module tb_cache_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, wdata, rdata, sram_address, sram_wdata;
  logic        MEM_R_EN, MEM_W_EN, ready, sram_r_en, sram_w_en, sram_ready;
  logic [63:0] sram_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  // SRAM contents: stored words override a fixed address-derived pattern.
  logic [31:0] mem_w [int];

  function automatic logic [31:0] word_of(input logic [31:0] wa);
    if (mem_w.exists(int'(wa[18:2]))) return mem_w[int'(wa[18:2])];
    if (wa[18:3] == 16'h0002) return wa[2] ? 32'h2222_2222 : 32'h1111_1111;
    return 32'hC000_0000 | {13'b0, wa[18:2], 2'b00};
  endfunction

  function automatic logic [63:0] line_of(input logic [31:0] a);
    logic [31:0] base;
    base = {a[31:3], 3'b000};
    return {word_of(base + 32'd4), word_of(base)};
  endfunction

  // SRAM controller model: enable seen in cycle 1, sram_ready in cycle 6.
  logic [2:0]  sram_cnt;
  logic [63:0] line_q;
  assign sram_ready = (sram_r_en | sram_w_en) && (sram_cnt == 3'd5);
  assign sram_rdata = line_q;

  always @(posedge clk or posedge rst) begin
    if (rst)                          sram_cnt <= '0;
    else if (sram_ready)              sram_cnt <= '0;
    else if (sram_r_en || sram_w_en)  sram_cnt <= sram_cnt + 3'd1;
  end

  always @(posedge clk) begin
    if (sram_r_en) line_q <= line_of(sram_address);
    if (sram_w_en && sram_ready) mem_w[int'(sram_address[18:2])] = sram_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wd;
    logic        txn;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, {63'b0, ready}, 64'd1);
    chk({tag, "_sram_en"}, {62'b0, sram_r_en, sram_w_en}, 64'd0);
    chk({tag, "_rdata"}, {32'b0, rdata}, 64'd0);
  endtask

  task automatic do_req(input vec_t v, input int n);
    int k;
    logic [1:0] exp_en;
    @(negedge clk);
    address = v.addr; wdata = v.wd; MEM_R_EN = v.rd; MEM_W_EN = v.wr;
    #1;
    if (!v.txn) begin
      chk($sformatf("v%0d_hit_ready", n), {63'b0, ready}, 64'd1);
      chk($sformatf("v%0d_hit_rdata", n), {32'b0, rdata}, {32'b0, v.exp});
      chk($sformatf("v%0d_hit_sram_en", n), {62'b0, sram_r_en, sram_w_en}, 64'd0);
    end else begin
      exp_en = v.wr ? 2'b01 : 2'b10;
      chk($sformatf("v%0d_c0_ready", n), {63'b0, ready}, 64'd0);
      chk($sformatf("v%0d_c0_sram_en", n), {62'b0, sram_r_en, sram_w_en}, 64'd0);
      k = 0;
      do begin
        @(negedge clk); #1;
        k++;
        chk($sformatf("v%0d_c%0d_sram_en", n, k), {62'b0, sram_r_en, sram_w_en}, {62'b0, exp_en});
      end while (!ready && k < 12);
      chk($sformatf("v%0d_ready_cycle", n), 64'(k), 64'd6);
      chk($sformatf("v%0d_done_rdata", n), {32'b0, rdata}, {32'b0, v.exp});
    end
  endtask

  initial begin
    rst = 1'b1; address = '0; wdata = '0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_idle("in_reset");
    rst = 1'b0;
    @(negedge clk); #1 check_idle("after_reset");

    //              addr          rd    wr    wdata          txn   expected rdata
    vecs.push_back('{32'h0000_0010, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1111_1111});
    vecs.push_back('{32'h0000_0014, 1'b1, 1'b0, 32'h0,         1'b0, 32'h2222_2222});
    vecs.push_back('{32'h0000_0008, 1'b1, 1'b0, 32'h0,         1'b1, 32'hC000_0008});
    vecs.push_back('{32'h0000_0208, 1'b1, 1'b0, 32'h0,         1'b1, 32'hC000_0208});
    vecs.push_back('{32'h0000_0008, 1'b1, 1'b0, 32'h0,         1'b0, 32'hC000_0008});
    vecs.push_back('{32'h0000_0408, 1'b1, 1'b0, 32'h0,         1'b1, 32'hC000_0408});
    vecs.push_back('{32'h0000_0008, 1'b1, 1'b0, 32'h0,         1'b0, 32'hC000_0008});
    vecs.push_back('{32'h0000_0208, 1'b1, 1'b0, 32'h0,         1'b1, 32'hC000_0208});
    vecs.push_back('{32'h0000_0010, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0});
    vecs.push_back('{32'h0000_0010, 1'b1, 1'b0, 32'h0,         1'b0, 32'hDEAD_BEEF});
    vecs.push_back('{32'h0000_0014, 1'b1, 1'b0, 32'h0,         1'b0, 32'h2222_2222});
    vecs.push_back('{32'h0000_1000, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 32'h0});
    vecs.push_back('{32'h0000_1000, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1234_5678});
    vecs.push_back('{32'h0000_1004, 1'b1, 1'b0, 32'h0,         1'b0, 32'hC000_1004});
    // Write hit on way0 of set 1 makes way1 the victim for the next miss.
    vecs.push_back('{32'h0000_0008, 1'b0, 1'b1, 32'hAAAA_5555, 1'b1, 32'h0});
    vecs.push_back('{32'h0000_0608, 1'b1, 1'b0, 32'h0,         1'b1, 32'hC000_0608});
    vecs.push_back('{32'h0000_0008, 1'b1, 1'b0, 32'h0,         1'b0, 32'hAAAA_5555});
    vecs.push_back('{32'h0000_0208, 1'b1, 1'b0, 32'h0,         1'b1, 32'hC000_0208});

    foreach (vecs[i]) do_req(vecs[i], i);

    @(negedge clk);
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    #1 check_idle("idle_between");

    // Reset in cycle 3 of a read miss: enable drops at once, cache ends up empty.
    @(negedge clk);
    address = 32'h0000_0018; MEM_R_EN = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      chk($sformatf("rstmiss_c%0d_r_en", k), {63'b0, sram_r_en}, 64'd1);
    end
    rst = 1'b1;
    #1;
    chk("rstmiss_r_en_drop", {63'b0, sram_r_en}, 64'd0);
    chk("rstmiss_w_en", {63'b0, sram_w_en}, 64'd0);
    @(negedge clk);
    rst = 1'b0; MEM_R_EN = 1'b0;
    #1 check_idle("rstmiss_after");
    do_req('{32'h0000_0010, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF}, 100);
    do_req('{32'h0000_0008, 1'b1, 1'b0, 32'h0, 1'b1, 32'hAAAA_5555}, 101);
    do_req('{32'h0000_0014, 1'b1, 1'b0, 32'h0, 1'b0, 32'h2222_2222}, 102);

    @(negedge clk);
    MEM_R_EN = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
